// File: rtl/instruction_decode.sv
// IITB-RISC decode stage: one registered 41-bit decoded word per cycle, valid/ready on both sides.
// Optional feature macro DECODE_LMSM_EN: LM/SM micro-op expansion (otherwise LM/SM decode as illegal).
module instruction_decode (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr_in,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        flush,
    output logic [40:0] instr_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        illegal_op
);
    localparam logic [3:0] OP_ADI = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_JAL = 4'b1001;
    localparam logic [3:0] OP_JRI = 4'b1011;

    logic [40:0] instr_out_r;
    logic [40:0] instr_out_nxt_s;
    logic        out_valid_r;
    logic        out_valid_nxt_s;
    logic        illegal_op_r;
    logic        illegal_op_nxt_s;
    logic        instr_ready_s;
    logic        accept_s;
    logic        handshake_s;
    logic        unused_bits_s;

    function automatic logic [40:0] decode_word(input logic [15:0] ins);
        logic [2:0]  rb;
        logic [15:0] field;
        rb    = ins[8:6];
        field = 16'h0000;
        case (ins[15:12])
            OP_ADD, OP_NDU:                 field = {ins[5:3], ins[1:0], 11'h000};
            OP_ADI, OP_LW, OP_SW, OP_BEQ:   field = {{10{ins[5]}}, ins[5:0]};
            OP_LHI: begin
                rb    = 3'd0;
                field = {ins[8:0], 7'h00};
            end
            OP_JAL, OP_JRI: begin
                rb    = 3'd0;
                field = {{7{ins[8]}}, ins[8:0]};
            end
            default:                        field = 16'h0000;
        endcase
        return {ins[15:12], ins[11:9], rb, field, 1'b1, 14'h0000};
    endfunction

    function automatic logic is_illegal(input logic [3:0] op);
`ifdef DECODE_LMSM_EN
        return (op[3:2] == 2'b11);
`else
        return (op[3:2] == 2'b11) || (op[3:1] == 3'b011);
`endif
    endfunction

    assign unused_bits_s = instr_in[2];

`ifdef DECODE_LMSM_EN
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXPAND = 1'b1} state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [7:0] mask_r;
    logic [7:0] mask_nxt_s;
    logic [2:0] offset_r;
    logic [2:0] offset_nxt_s;
    logic [2:0] offset_inc_s;
    logic [2:0] base_r;
    logic [2:0] base_nxt_s;
    logic [3:0] lmsm_op_r;
    logic [3:0] lmsm_op_nxt_s;
    logic [7:0] sel_mask_s;
    logic [2:0] sel_reg_s;
    logic [7:0] sel_rem_s;

    // Mask bit 7 selects R0, so the lowest-numbered register is the highest set bit.
    function automatic logic [2:0] first_reg(input logic [7:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            r = m[i] ? 3'(7 - i) : r;
        end
        return r;
    endfunction

    assign sel_mask_s   = (mask_r != 8'h00) ? mask_r : instr_in[7:0];
    assign sel_reg_s    = first_reg(sel_mask_s);
    assign sel_rem_s    = sel_mask_s & ~(8'h80 >> sel_reg_s);
    assign offset_inc_s = offset_r + 3'd1;
    assign instr_ready_s = rst_n && !flush && (!out_valid_r || out_ready) && (mask_r == 8'h00);
`else
    assign instr_ready_s = rst_n && !flush && (!out_valid_r || out_ready);
`endif

    assign accept_s    = instr_valid && instr_ready_s;
    assign handshake_s = out_valid_r && out_ready;

    // Next-state decode: flush first, then accept, then micro-op advance or drain.
    always_comb begin
        instr_out_nxt_s  = instr_out_r;
        out_valid_nxt_s  = out_valid_r;
        illegal_op_nxt_s = 1'b0;
`ifdef DECODE_LMSM_EN
        state_nxt_s   = state_r;
        mask_nxt_s    = mask_r;
        offset_nxt_s  = offset_r;
        base_nxt_s    = base_r;
        lmsm_op_nxt_s = lmsm_op_r;
`endif
        if (flush) begin
            out_valid_nxt_s = 1'b0;
`ifdef DECODE_LMSM_EN
            state_nxt_s  = ST_IDLE;
            mask_nxt_s   = 8'h00;
            offset_nxt_s = 3'd0;
`endif
        end else if (accept_s) begin
            if (is_illegal(instr_in[15:12])) begin
                out_valid_nxt_s  = 1'b0;
                illegal_op_nxt_s = 1'b1;
`ifdef DECODE_LMSM_EN
                state_nxt_s  = ST_IDLE;
                mask_nxt_s   = 8'h00;
                offset_nxt_s = 3'd0;
            end else if (instr_in[15:13] == 3'b011) begin
                lmsm_op_nxt_s   = instr_in[15:12];
                base_nxt_s      = instr_in[11:9];
                offset_nxt_s    = 3'd0;
                mask_nxt_s      = sel_rem_s;
                out_valid_nxt_s = (instr_in[7:0] != 8'h00);
                state_nxt_s     = (sel_rem_s != 8'h00) ? ST_EXPAND : ST_IDLE;
                if (instr_in[7:0] != 8'h00) begin
                    instr_out_nxt_s = {instr_in[15:12], instr_in[11:9], sel_reg_s, 16'h0000,
                                       (sel_rem_s == 8'h00), 14'h0000};
                end else begin
                    instr_out_nxt_s = instr_out_r;
                end
`endif
            end else begin
                instr_out_nxt_s = decode_word(instr_in);
                out_valid_nxt_s = 1'b1;
`ifdef DECODE_LMSM_EN
                state_nxt_s  = ST_IDLE;
                mask_nxt_s   = 8'h00;
                offset_nxt_s = 3'd0;
`endif
            end
        end else if (handshake_s) begin
`ifdef DECODE_LMSM_EN
            if ((state_r == ST_EXPAND) && (mask_r != 8'h00)) begin
                offset_nxt_s    = offset_inc_s;
                mask_nxt_s      = sel_rem_s;
                instr_out_nxt_s = {lmsm_op_r, base_r, sel_reg_s, 13'h0000, offset_inc_s,
                                   (sel_rem_s == 8'h00), 14'h0000};
            end else begin
                out_valid_nxt_s = 1'b0;
                state_nxt_s     = ST_IDLE;
                offset_nxt_s    = 3'd0;
            end
`else
            out_valid_nxt_s = 1'b0;
`endif
        end else begin
            out_valid_nxt_s = out_valid_r;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_out_r  <= 41'h0;
            out_valid_r  <= 1'b0;
            illegal_op_r <= 1'b0;
        end else begin
            instr_out_r  <= instr_out_nxt_s;
            out_valid_r  <= out_valid_nxt_s;
            illegal_op_r <= illegal_op_nxt_s;
        end
    end

`ifdef DECODE_LMSM_EN
    // Expansion state: remaining mask, emitted count, base register and opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            mask_r    <= 8'h00;
            offset_r  <= 3'd0;
            base_r    <= 3'd0;
            lmsm_op_r <= 4'd0;
        end else begin
            state_r   <= state_nxt_s;
            mask_r    <= mask_nxt_s;
            offset_r  <= offset_nxt_s;
            base_r    <= base_nxt_s;
            lmsm_op_r <= lmsm_op_nxt_s;
        end
    end
`endif

    assign instr_ready = instr_ready_s;
    assign instr_out   = instr_out_r;
    assign out_valid   = out_valid_r;
    assign illegal_op  = illegal_op_r;
endmodule

// File: tb/tb_instruction_decode.sv
// Scoreboard bench for instruction_decode: directed spec cases plus randomized instructions.
module tb_instruction_decode;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr_in;
    logic        instr_valid;
    logic        instr_ready;
    logic        flush;
    logic [40:0] instr_out;
    logic        out_valid;
    logic        out_ready;
    logic        illegal_op;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .flush(flush), .instr_out(instr_out),
        .out_valid(out_valid), .out_ready(out_ready), .illegal_op(illegal_op)
    );

    int          n_checks = 0;
    int          n_fail = 0;
    logic [40:0] exp_q[$];
    int          exp_illegal = 0;
    bit          mon_en = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          prev_stall = 1'b0;
    logic [40:0] prev_word;
    int          w;
    int          n_low;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [40:0] mk(input int op, input int ra, input int rb, input int fld, input bit last);
        logic [40:0] x;
        x = 41'h0;
        x[40:37] = op[3:0];
        x[36:34] = ra[2:0];
        x[33:31] = rb[2:0];
        x[30:15] = fld[15:0];
        x[14]    = last;
        return x;
    endfunction

    // Reference model: list of words (or an illegal pulse) an accepted instruction must produce.
    task automatic model_push(input logic [15:0] ins);
        int op, ra, rb, rc, cz, imm6, imm9, fld, total, n;
        bit lmsm;
`ifdef DECODE_LMSM_EN
        lmsm = 1'b1;
`else
        lmsm = 1'b0;
`endif
        op = int'(ins[15:12]); ra = int'(ins[11:9]); rb = int'(ins[8:6]);
        rc = int'(ins[5:3]);   cz = int'(ins[1:0]);  imm6 = int'(ins[5:0]); imm9 = int'(ins[8:0]);
        if (op >= 12 || (!lmsm && (op == 6 || op == 7))) begin
            exp_illegal++;
        end else if (op == 6 || op == 7) begin
            total = $countones(ins[7:0]);
            n = 0;
            for (int r = 0; r < 8; r++) begin
                if (ins[7 - r]) begin
                    exp_q.push_back(mk(op, ra, r, n, n == total - 1));
                    n++;
                end
            end
        end else begin
            case (op)
                1, 2:       fld = rc * 8192 + cz * 2048;
                0, 4, 5, 8: fld = (imm6 >= 32) ? imm6 - 64 : imm6;
                3:          begin fld = imm9 * 128; rb = 0; end
                9, 11:      begin fld = (imm9 >= 256) ? imm9 - 512 : imm9; rb = 0; end
                default:    fld = 0;
            endcase
            exp_q.push_back(mk(op, ra, rb, fld, 1'b1));
        end
    endtask

    task automatic send(input logic [15:0] ins, output int waits);
        waits = 0;
        instr_in = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 200) check("accept_timeout", waits, 0);
        model_push(ins);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    // Monitor: pops expected words on each output handshake, tracks stall stability and illegal pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_word_held", instr_out, prev_word);
            end
            if (out_valid && out_ready && !flush) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("decoded_word", instr_out, exp_q.pop_front());
            end
            if (illegal_op) begin
                check("illegal_expected", exp_illegal > 0, 1);
                if (exp_illegal > 0) exp_illegal--;
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_word  = instr_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; instr_in = 16'h0; instr_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_instr_out", instr_out, 0);
        check("rst_illegal", illegal_op, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_instr_ready", instr_ready, 1);
        mon_en = 1'b1;
        @(posedge clk); #1;

        send(16'h1298, w);
        check("add_valid", out_valid, 1);
        check("add_word", instr_out, {4'b0001, 3'd1, 3'd2, 16'h6000, 1'b1, 14'h0});
        send(16'h02BF, w);
        check("adi_word", instr_out, {4'b0000, 3'd1, 3'd2, 16'hFFFF, 1'b1, 14'h0});

        for (int i = 0; i < 8; i++) begin
            send({4'b0100, 12'($urandom_range(0, 4095))}, w);
            check("b2b_no_wait", w, 0);
            check("b2b_valid", out_valid, 1);
        end

`ifdef DECODE_LMSM_EN
        send(16'h6681, w);
        check("lm_first_word", instr_out, {4'b0110, 3'd3, 3'd0, 16'h0000, 1'b0, 14'h0});
        n_low = 0;
        @(negedge clk);
        while (!instr_ready && n_low < 10) begin
            n_low++;
            @(negedge clk);
        end
        check("lm_ready_low_cycles", n_low, 1);
        check("lm_second_word", instr_out, {4'b0110, 3'd3, 3'd7, 16'h0001, 1'b1, 14'h0});
        @(posedge clk); #1;
`else
        send(16'h6681, w);
        check("lm_illegal_pulse", illegal_op, 1);
        check("lm_no_output", out_valid, 0);
        @(posedge clk); #1;
        check("lm_pulse_single", illegal_op, 0);
`endif

        out_ready = 1'b0;
        send(16'h5A47, w);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_ready_low", instr_ready, 0);
            check("bp_valid_held", out_valid, 1);
        end
        @(posedge clk); #1;
        flush = 1'b1; instr_in = 16'h1298; instr_valid = 1'b1;
        @(negedge clk);
        check("flush_ready_low", instr_ready, 0);
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0; out_ready = 1'b1;
        check("flush_clears_valid", out_valid, 0);

`ifdef DECODE_LMSM_EN
        send(16'h72FF, w);
        repeat (2) begin @(posedge clk); #1; end
        check("sm_third_offset", instr_out[30:15], 16'd2);
        flush = 1'b1; out_ready = 1'b0; instr_in = 16'h02BF; instr_valid = 1'b1;
        @(negedge clk);
        check("sm_flush_ready_low", instr_ready, 0);
        exp_q.delete();
        @(posedge clk); #1;
        flush = 1'b0; instr_valid = 1'b0; out_ready = 1'b1;
        check("sm_flush_valid", out_valid, 0);
        check("sm_flush_ready_back", instr_ready, 1);
`endif
        send(16'h1298, w);
        check("post_flush_wait", w, 0);
        check("post_flush_word", instr_out, {4'b0001, 3'd1, 3'd2, 16'h6000, 1'b1, 14'h0});

        send(16'hF123, w);
        check("illegal_pulse", illegal_op, 1);
        check("illegal_no_output", out_valid, 0);
        @(posedge clk); #1;
        check("illegal_single", illegal_op, 0);

        out_ready = 1'b0;
`ifdef DECODE_LMSM_EN
        send(16'h66FF, w);
`else
        send(16'h1298, w);
`endif
        @(negedge clk);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_word", instr_out, 0);
        check("rst_mid_illegal", illegal_op, 0);
        check("rst_mid_ready", instr_ready, 0);
        exp_q.delete();
        exp_illegal = 0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        check("rst_release_ready", instr_ready, 1);
        mon_en = 1'b1;

        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(16'($urandom_range(0, 65535)), w);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_illegal_pending", exp_illegal, 0);
        check("final_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
